ts_core_dispatch: RTL and testbench
===================================

Name: ts_core_dispatch

Overview:
- Parametrised successor to the fixed 16-core task-scheduler-to-core fan-out.
- Accepts one word at a time (instruction or config) from the task scheduler, together with a per-word core mask.
- Drives the word to every masked core, holding valid per core until that core accepts. Stalls the scheduler until all targets have taken the word, or a timeout expires.
- Registers core ready/rtr status back to the scheduler, and keeps drop/timeout diagnostics.

Parameters:
N_CORES, 16, number of core channels (1..32)
DATA_W, 16, instruction/config word width
TIMEOUT, 255, max cycles a word may wait for acceptance; 0 disables timeout
CNT_W, 16, width of diagnostic counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ts_valid  in  1  scheduler word valid
ts_ready  out  1  dispatcher can take a word this cycle
ts_kind  in  1  0 = instruction (if), 1 = config (cf)
ts_data  in  DATA_W  word
ts_mask  in  N_CORES  target cores; bit i = core i
core_data  out  DATA_W  shared word bus to all cores
core_if_val  out  N_CORES  per-core instruction valid
core_cf_val  out  N_CORES  per-core config valid
core_accept  in  N_CORES  core i takes word when its val and accept are both high
core_ready  in  N_CORES  core idle/ready status
core_rtr  in  N_CORES  core ready-to-receive status
ready_bus  out  N_CORES  core_ready registered once
rtr_bus  out  N_CORES  core_rtr registered once
busy  out  1  a word is outstanding
err_timeout  out  1  sticky; set on any timeout abort
stuck_mask  out  N_CORES  pending mask at the most recent timeout
drop_cnt  out  CNT_W  words accepted with an all-zero mask
timeout_cnt  out  CNT_W  number of timeout aborts
err_clr  in  1  clears err_timeout, stuck_mask and both counters

Behaviour:
- Reset (async on rst_n low, released synchronously by design convention):
  - All outputs are 0.
  - State = IDLE, pending = 0, wait counter = 0.
- States:
  - IDLE: ts_ready = 1.
  - ISSUE: pending != 0.
- Handshake:
  - A word transfers on ts_valid & ts_ready.
  - On transfer with nonzero mask: latch ts_data into core_data and ts_kind into a kind register; pending <= ts_mask; wait counter <= 0; next state ISSUE.
  - Latency: valids appear the cycle after transfer.
  - On transfer with zero mask: word dropped; drop_cnt += 1 (saturating); state unchanged.
- Valids: core_if_val = pending & {N{~kind}}; core_cf_val = pending & {N{kind}}. The two are never both set for one core.
- ISSUE, each cycle:
  - pending_next = pending & ~core_accept. Accept on a non-pending bit is ignored.
  - Wait counter += 1.
- ts_ready in ISSUE = (pending_next == 0). This allows back-to-back issue: a new word may transfer in the same cycle the last target accepts, with no bubble.
  - If a new word transfers then: load it (nonzero mask → stay in ISSUE; zero mask → count drop, go to IDLE).
  - Otherwise: go to IDLE.
- core_data holds stable while busy; it changes only on a transfer.
- Timeout (TIMEOUT > 0):
  - When the wait counter reaches TIMEOUT and pending_next != 0: stuck_mask <= pending_next; err_timeout <= 1; timeout_cnt += 1 (saturating); pending <= 0; state IDLE.
  - ts_ready is 0 in that cycle.
  - If pending_next == 0 in that same cycle, completion wins and no timeout is recorded.
- busy = (state == ISSUE).
- Status: ready_bus <= core_ready and rtr_bus <= core_rtr every cycle, independent of state.
- err_clr:
  - Synchronous clear.
  - If a timeout event coincides with err_clr, the event wins: flag set, counter = 1.
  - If a drop coincides with err_clr, drop_cnt = 1.
- Reset mid-ISSUE: all valids drop asynchronously and the word is lost; the scheduler reissues it.
- Counters saturate at all-ones and do not wrap.

Decomposition:
- Package ts_dispatch_pkg holds:
  - the kind encoding constants (KIND_IF = 0, KIND_CF = 1);
  - the state enum (IDLE, ISSUE);
  - a saturating-increment function shared by both counters.
- One natural sub-module: ts_dispatch_diag, containing the drop/timeout counters, the sticky flag, stuck_mask and err_clr logic.
- The main block keeps the FSM, the pending mask, the wait counter and the status registers.

Test Plan:
- Broadcast: mask 0xFFFF, kind 0, data 0x1234; all cores accept next cycle → core_if_val = 0xFFFF for 1 cycle, core_cf_val = 0, ts_ready returns 1 in the accept cycle, busy 1 for one cycle.
- Staggered accept: mask 0x0005; core 0 accepts at cycle 1, core 2 at cycle 4 → core_if_val 0x0005 → 0x0004 (cycles 2–4) → 0; a second word held on ts_valid transfers in cycle 4 with no bubble.
- Config kind: kind 1, mask 0x8000, data 0xABCD → only core_cf_val[15] high; core_data = 0xABCD stable until accept, even if ts_data changes.
- Zero mask: three words with mask 0 → ts_ready stays 1, no valids, drop_cnt = 3; err_clr → drop_cnt = 0.
- Timeout: TIMEOUT = 8, mask 0x0003, only core 0 accepts → after 8 waiting cycles err_timeout = 1, stuck_mask = 0x0002, timeout_cnt = 1, valids 0, ts_ready 1 the next cycle; accept arriving exactly at cycle 8 → no timeout.
- Reset mid-issue: rst_n low while pending = 0x00F0 → valids, busy and ready_bus go 0 immediately; after release ts_ready = 1 and counters = 0. N_CORES = 4 and N_CORES = 32 elaborations repeat the broadcast scenario.

Source files
------------

// File: rtl/ts_dispatch_pkg.sv
// Shared types and helpers for the task-scheduler-to-core dispatcher.
package ts_dispatch_pkg;

    // Word kind carried alongside each scheduler word
    localparam logic KIND_IF = 1'b0;
    localparam logic KIND_CF = 1'b1;

    // Dispatcher FSM states
    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Saturating increment for counters up to 32 bits wide; w is the live width
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [32:0] lim;
        logic [31:0] max_v;
        lim   = (33'(1) << w) - 33'(1);
        max_v = lim[31:0];
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ts_core_dispatch_if.sv
// Scheduler-side word handshake.
// Valid/ready: a word transfers on a cycle where ts_valid and ts_ready are both
// high; the scheduler keeps ts_valid, ts_kind, ts_data and ts_mask stable until then.
interface ts_core_dispatch_if #(
    parameter int N_CORES = 16,
    parameter int DATA_W  = 16
) ();
    logic                ts_valid;
    logic                ts_ready;
    logic                ts_kind;
    logic [DATA_W-1:0]   ts_data;
    logic [N_CORES-1:0]  ts_mask;

    // Scheduler side
    modport master (
        output ts_valid, ts_kind, ts_data, ts_mask,
        input  ts_ready
    );

    // Dispatcher side
    modport slave (
        input  ts_valid, ts_kind, ts_data, ts_mask,
        output ts_ready
    );
endinterface

// File: rtl/ts_dispatch_diag.sv
// Drop/timeout diagnostics: saturating counters, sticky timeout flag and stuck mask.
module ts_dispatch_diag #(
    parameter int N_CORES = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               drop_evt,
    input  logic               timeout_evt,
    input  logic [N_CORES-1:0] stuck_in,
    input  logic               err_clr,
    output logic               err_timeout,
    output logic [N_CORES-1:0] stuck_mask,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [CNT_W-1:0]   timeout_cnt
);
    import ts_dispatch_pkg::*;

    // Count dropped zero-mask words; a coincident clear leaves this event counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_evt) begin
            drop_cnt <= err_clr ? CNT_W'(1) : CNT_W'(sat_inc(32'(drop_cnt), CNT_W));
        end else if (err_clr) begin
            drop_cnt <= '0;
        end
    end

    // Timeout bookkeeping; a timeout in the same cycle as a clear is still recorded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout <= 1'b0;
            stuck_mask  <= '0;
            timeout_cnt <= '0;
        end else if (timeout_evt) begin
            err_timeout <= 1'b1;
            stuck_mask  <= stuck_in;
            timeout_cnt <= err_clr ? CNT_W'(1) : CNT_W'(sat_inc(32'(timeout_cnt), CNT_W));
        end else if (err_clr) begin
            err_timeout <= 1'b0;
            stuck_mask  <= '0;
            timeout_cnt <= '0;
        end
    end

endmodule

// File: rtl/ts_core_dispatch.sv
// Fans one scheduler word out to a masked set of cores, holding each core's
// valid until it accepts, with an optional acceptance timeout.
module ts_core_dispatch #(
    parameter int N_CORES = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    ts_core_dispatch_if.slave  ts,
    output logic [DATA_W-1:0]  core_data,
    output logic [N_CORES-1:0] core_if_val,
    output logic [N_CORES-1:0] core_cf_val,
    input  logic [N_CORES-1:0] core_accept,
    input  logic [N_CORES-1:0] core_ready,
    input  logic [N_CORES-1:0] core_rtr,
    output logic [N_CORES-1:0] ready_bus,
    output logic [N_CORES-1:0] rtr_bus,
    output logic               busy,
    output logic               err_timeout,
    output logic [N_CORES-1:0] stuck_mask,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [CNT_W-1:0]   timeout_cnt,
    input  logic               err_clr
);
    import ts_dispatch_pkg::*;

    // Wide enough to hold TIMEOUT; one bit when the timeout is disabled
    localparam int          WAIT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [31:0] TIMEOUT_L = 32'(TIMEOUT);

    state_t              state;
    state_t              state_next;
    logic [N_CORES-1:0]  pending;
    logic [N_CORES-1:0]  pending_next;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W:0]     wait_inc;
    logic                kind_q;
    logic [DATA_W-1:0]   data_q;
    logic                ready_int;
    logic                xfer;
    logic                load;
    logic                drop;
    logic                timeout_hit;

    // Targets still outstanding after this cycle's accepts
    assign pending_next = pending & ~core_accept;
    assign wait_inc     = {1'b0, wait_cnt} + (WAIT_W + 1)'(1);

    // Ready when idle, or when the last target accepts this cycle (no bubble);
    // held low while in reset
    assign ready_int = rst_n & ((state == IDLE) | (pending_next == '0));
    assign xfer      = ts.ts_valid & ready_int;
    assign load      = xfer & (ts.ts_mask != '0);
    assign drop      = xfer & (ts.ts_mask == '0);

    // Abort only when targets remain; completion in the deadline cycle wins
    assign timeout_hit = (TIMEOUT_L != 32'd0) && (state == ISSUE) &&
                         (32'(wait_inc) >= TIMEOUT_L) && (pending_next != '0);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load) state_next = ISSUE;
            end
            ISSUE: begin
                if (timeout_hit) begin
                    state_next = IDLE;
                end else if (pending_next == '0) begin
                    state_next = load ? ISSUE : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: per-core valids split by kind, handshake ready, busy
    always_comb begin
        ts.ts_ready = ready_int;
        busy        = (state == ISSUE);
        core_data   = data_q;
        core_if_val = pending & ~{N_CORES{kind_q == KIND_CF}};
        core_cf_val = pending &  {N_CORES{kind_q == KIND_CF}};
    end

    // Pending mask and wait counter: load on transfer, clear on timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            wait_cnt <= '0;
        end else if (load) begin
            pending  <= ts.ts_mask;
            wait_cnt <= '0;
        end else if (timeout_hit) begin
            pending  <= '0;
            wait_cnt <= wait_inc[WAIT_W-1:0];
        end else if (state == ISSUE) begin
            pending  <= pending_next;
            wait_cnt <= wait_inc[WAIT_W-1:0];
        end
    end

    // Word and kind capture; only a transfer with targets changes the bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            kind_q <= KIND_IF;
        end else if (load) begin
            data_q <= ts.ts_data;
            kind_q <= ts.ts_kind;
        end
    end

    // Core status registered once toward the scheduler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_bus <= '0;
            rtr_bus   <= '0;
        end else begin
            ready_bus <= core_ready;
            rtr_bus   <= core_rtr;
        end
    end

    ts_dispatch_diag #(
        .N_CORES (N_CORES),
        .CNT_W   (CNT_W)
    ) u_diag (
        .clk         (clk),
        .rst_n       (rst_n),
        .drop_evt    (drop),
        .timeout_evt (timeout_hit),
        .stuck_in    (pending_next),
        .err_clr     (err_clr),
        .err_timeout (err_timeout),
        .stuck_mask  (stuck_mask),
        .drop_cnt    (drop_cnt),
        .timeout_cnt (timeout_cnt)
    );

endmodule

// File: tb/tb_ts_core_dispatch.sv
// Directed bench for ts_core_dispatch: 16-core (TIMEOUT 8), 4-core (2-bit
// counters) and 32-core elaborations.
module tb_ts_core_dispatch;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    // ---------------- 16-core DUT ----------------
    ts_core_dispatch_if #(.N_CORES(16), .DATA_W(16)) sif ();
    logic [15:0] core_data, core_if_val, core_cf_val, core_accept, core_ready, core_rtr;
    logic [15:0] ready_bus, rtr_bus, stuck_mask, drop_cnt, timeout_cnt;
    logic        busy, err_timeout, err_clr;

    ts_core_dispatch #(.N_CORES(16), .DATA_W(16), .TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ts(sif),
        .core_data(core_data), .core_if_val(core_if_val), .core_cf_val(core_cf_val),
        .core_accept(core_accept), .core_ready(core_ready), .core_rtr(core_rtr),
        .ready_bus(ready_bus), .rtr_bus(rtr_bus), .busy(busy),
        .err_timeout(err_timeout), .stuck_mask(stuck_mask),
        .drop_cnt(drop_cnt), .timeout_cnt(timeout_cnt), .err_clr(err_clr)
    );

    // ---------------- 4-core DUT ----------------
    ts_core_dispatch_if #(.N_CORES(4), .DATA_W(16)) sif4 ();
    logic [15:0] d4_data;
    logic [3:0]  d4_if_val, d4_cf_val, d4_accept, d4_ready_bus, d4_rtr_bus, d4_stuck;
    logic [1:0]  d4_drop_cnt, d4_to_cnt;
    logic        d4_busy, d4_err;

    ts_core_dispatch #(.N_CORES(4), .DATA_W(16), .TIMEOUT(255), .CNT_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .ts(sif4),
        .core_data(d4_data), .core_if_val(d4_if_val), .core_cf_val(d4_cf_val),
        .core_accept(d4_accept), .core_ready(4'h0), .core_rtr(4'h0),
        .ready_bus(d4_ready_bus), .rtr_bus(d4_rtr_bus), .busy(d4_busy),
        .err_timeout(d4_err), .stuck_mask(d4_stuck),
        .drop_cnt(d4_drop_cnt), .timeout_cnt(d4_to_cnt), .err_clr(1'b0)
    );

    // ---------------- 32-core DUT ----------------
    ts_core_dispatch_if #(.N_CORES(32), .DATA_W(16)) sif32 ();
    logic [15:0] d32_data, d32_drop_cnt, d32_to_cnt;
    logic [31:0] d32_if_val, d32_cf_val, d32_accept, d32_ready_bus, d32_rtr_bus, d32_stuck;
    logic        d32_busy, d32_err;

    ts_core_dispatch #(.N_CORES(32), .DATA_W(16), .TIMEOUT(255), .CNT_W(16)) dut32 (
        .clk(clk), .rst_n(rst_n), .ts(sif32),
        .core_data(d32_data), .core_if_val(d32_if_val), .core_cf_val(d32_cf_val),
        .core_accept(d32_accept), .core_ready(32'h0), .core_rtr(32'h0),
        .ready_bus(d32_ready_bus), .rtr_bus(d32_rtr_bus), .busy(d32_busy),
        .err_timeout(d32_err), .stuck_mask(d32_stuck),
        .drop_cnt(d32_drop_cnt), .timeout_cnt(d32_to_cnt), .err_clr(1'b0)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic kind, input logic [15:0] data, input logic [15:0] mask);
        sif.ts_valid = 1'b1;
        sif.ts_kind  = kind;
        sif.ts_data  = data;
        sif.ts_mask  = mask;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        logic [15:0] exp_w;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0h expected queued word (queue empty)", tag, core_data);
        end else begin
            exp_w = exp_q.pop_front();
            check(tag, core_data, exp_w);
        end
    endtask

    // Word to cores 0 and 1; core 0 accepts at once, core 1 either accepts in
    // the deadline cycle (late=1) or never; optional err_clr in the deadline cycle.
    task automatic run_mask3(input string tag, input logic late, input logic clr,
                             input logic [15:0] exp_cnt, input logic exp_err,
                             input logic [15:0] exp_stuck);
        send(1'b0, 16'h7777, 16'h0003);
        exp_q.push_back(16'h7777);
        #1 check({tag, "_ready_c0"}, sif.ts_ready, 1'b1);
        step();
        sif.ts_valid = 1'b0;
        core_accept  = 16'h0001;
        #1 check({tag, "_ifval_c1"}, core_if_val, 16'h0003);
        sb_check({tag, "_data_c1"});
        step();
        core_accept = 16'h0000;
        for (int c = 2; c <= 7; c++) begin
            if (c == 7) check({tag, "_ifval_c7"}, core_if_val, 16'h0002);
            step();
        end
        core_accept = late ? 16'h0002 : 16'h0000;
        err_clr     = clr;
        #1 check({tag, "_ready_c8"}, sif.ts_ready, late);
        check({tag, "_ifval_c8"}, core_if_val, 16'h0002);
        step();
        core_accept = 16'h0000;
        err_clr     = 1'b0;
        #1;
        check({tag, "_err"}, err_timeout, exp_err);
        check({tag, "_stuck"}, stuck_mask, exp_stuck);
        check({tag, "_tocnt"}, timeout_cnt, exp_cnt);
        check({tag, "_ifval_c9"}, core_if_val, 16'h0000);
        check({tag, "_busy_c9"}, busy, 1'b0);
        check({tag, "_ready_c9"}, sif.ts_ready, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        sif.ts_valid = 1'b0; sif.ts_kind = 1'b0; sif.ts_data = '0; sif.ts_mask = '0;
        sif4.ts_valid = 1'b0; sif4.ts_kind = 1'b0; sif4.ts_data = '0; sif4.ts_mask = '0;
        sif32.ts_valid = 1'b0; sif32.ts_kind = 1'b0; sif32.ts_data = '0; sif32.ts_mask = '0;
        core_accept = '0; core_ready = '0; core_rtr = '0; err_clr = 1'b0;
        d4_accept = '0; d32_accept = '0;

        // Reset values
        step(); step();
        check("rst_ready", sif.ts_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ifval", core_if_val, 16'h0);
        check("rst_data", core_data, 16'h0);
        check("rst_drop", drop_cnt, 16'h0);
        check("rst_err", err_timeout, 1'b0);
        rst_n = 1'b1;
        step();
        check("idle_ready", sif.ts_ready, 1'b1);

        // Broadcast instruction, all cores accept in the first valid cycle
        send(1'b0, 16'h1234, 16'hFFFF);
        exp_q.push_back(16'h1234);
        #1 check("bc_ready_idle", sif.ts_ready, 1'b1);
        step();
        sif.ts_valid = 1'b0;
        core_accept  = 16'hFFFF;
        #1 check("bc_ifval", core_if_val, 16'hFFFF);
        check("bc_cfval", core_cf_val, 16'h0000);
        check("bc_busy", busy, 1'b1);
        check("bc_ready_acc", sif.ts_ready, 1'b1);
        sb_check("bc_data");
        step();
        core_accept = 16'h0000;
        #1 check("bc_ifval_done", core_if_val, 16'h0000);
        check("bc_busy_done", busy, 1'b0);

        // Staggered accept with a second word waiting on ts_valid
        send(1'b0, 16'h1111, 16'h0005);
        exp_q.push_back(16'h1111);
        #1 step();
        send(1'b0, 16'h2222, 16'h0008);
        core_accept = 16'h0001;
        #1 check("st_ifval_c1", core_if_val, 16'h0005);
        check("st_ready_c1", sif.ts_ready, 1'b0);
        sb_check("st_data_c1");
        step();
        core_accept = 16'h0000;
        #1 check("st_ifval_c2", core_if_val, 16'h0004);
        step();
        check("st_ifval_c3", core_if_val, 16'h0004);
        check("st_ready_c3", sif.ts_ready, 1'b0);
        step();
        core_accept = 16'h0004;
        exp_q.push_back(16'h2222);
        #1 check("st_ifval_c4", core_if_val, 16'h0004);
        check("st_ready_c4", sif.ts_ready, 1'b1);
        step();
        sif.ts_valid = 1'b0;
        core_accept  = 16'h0008;
        #1 check("st_ifval_c5", core_if_val, 16'h0008);
        check("st_busy_c5", busy, 1'b1);
        sb_check("st_data_c5");
        step();
        core_accept = 16'h0000;
        #1 check("st_busy_c6", busy, 1'b0);
        check("st_ifval_c6", core_if_val, 16'h0000);

        // Config word; bus holds while the scheduler changes ts_data
        send(1'b1, 16'hABCD, 16'h8000);
        exp_q.push_back(16'hABCD);
        #1 step();
        sif.ts_valid = 1'b0;
        sif.ts_data  = 16'h5555;
        sif.ts_kind  = 1'b0;
        #1 check("cf_cfval", core_cf_val, 16'h8000);
        check("cf_ifval", core_if_val, 16'h0000);
        sb_check("cf_data");
        step();
        check("cf_data_hold", core_data, 16'hABCD);
        check("cf_cfval_hold", core_cf_val, 16'h8000);
        core_accept = 16'h8000;
        #1 check("cf_ready_acc", sif.ts_ready, 1'b1);
        step();
        core_accept = 16'h0000;
        #1 check("cf_busy_done", busy, 1'b0);
        check("cf_cfval_done", core_cf_val, 16'h0000);

        // Zero-mask words are dropped and counted
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 16'h0F0F, 16'h0000);
            #1 check("zm_ready", sif.ts_ready, 1'b1);
            step();
            check("zm_ifval", core_if_val, 16'h0000);
            check("zm_busy", busy, 1'b0);
        end
        sif.ts_valid = 1'b0;
        #1 check("zm_drop3", drop_cnt, 16'd3);
        check("zm_data_kept", core_data, 16'hABCD);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        #1 check("zm_drop_clr", drop_cnt, 16'd0);

        // Timeouts: plain abort, completion in the deadline cycle, abort with clear
        run_mask3("to_a", 1'b0, 1'b0, 16'd1, 1'b1, 16'h0002);
        run_mask3("to_late", 1'b1, 1'b0, 16'd1, 1'b1, 16'h0002);
        run_mask3("to_clr", 1'b0, 1'b1, 16'd1, 1'b1, 16'h0002);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        #1 check("to_clr_err", err_timeout, 1'b0);
        check("to_clr_cnt", timeout_cnt, 16'd0);
        check("to_clr_stuck", stuck_mask, 16'h0000);

        // Reset in the middle of an issue
        core_ready = 16'h00A5;
        core_rtr   = 16'h005A;
        send(1'b0, 16'h0F0F, 16'h0000);
        #1 step();
        send(1'b0, 16'h4242, 16'h00F0);
        #1 step();
        sif.ts_valid = 1'b0;
        #1 check("rm_ifval", core_if_val, 16'h00F0);
        check("rm_busy", busy, 1'b1);
        check("rm_ready_bus", ready_bus, 16'h00A5);
        check("rm_rtr_bus", rtr_bus, 16'h005A);
        check("rm_drop", drop_cnt, 16'd1);
        rst_n = 1'b0;
        #1 check("rm_ifval_rst", core_if_val, 16'h0000);
        check("rm_busy_rst", busy, 1'b0);
        check("rm_ready_bus_rst", ready_bus, 16'h0000);
        check("rm_drop_rst", drop_cnt, 16'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rm_ready_after", sif.ts_ready, 1'b1);
        check("rm_drop_after", drop_cnt, 16'd0);
        check("rm_tocnt_after", timeout_cnt, 16'd0);
        check("rm_ready_bus_after", ready_bus, 16'h00A5);

        // 4-core broadcast
        sif4.ts_valid = 1'b1; sif4.ts_kind = 1'b0; sif4.ts_data = 16'h0C0C; sif4.ts_mask = 4'hF;
        #1 step();
        sif4.ts_valid = 1'b0;
        d4_accept     = 4'hF;
        #1 check("n4_ifval", d4_if_val, 4'hF);
        check("n4_data", d4_data, 16'h0C0C);
        check("n4_busy", d4_busy, 1'b1);
        check("n4_ready_acc", sif4.ts_ready, 1'b1);
        step();
        d4_accept = 4'h0;
        #1 check("n4_busy_done", d4_busy, 1'b0);

        // 4-core 2-bit drop counter saturates at 3
        sif4.ts_mask  = 4'h0;
        sif4.ts_valid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        sif4.ts_valid = 1'b0;
        #1 check("n4_drop_sat", d4_drop_cnt, 2'd3);

        // 32-core broadcast
        sif32.ts_valid = 1'b1; sif32.ts_kind = 1'b0; sif32.ts_data = 16'h3232;
        sif32.ts_mask  = 32'hFFFF_FFFF;
        #1 step();
        sif32.ts_valid = 1'b0;
        d32_accept     = 32'hFFFF_FFFF;
        #1 check("n32_ifval", d32_if_val, 32'hFFFF_FFFF);
        check("n32_cfval", d32_cf_val, 32'h0);
        check("n32_data", d32_data, 16'h3232);
        check("n32_ready_acc", sif32.ts_ready, 1'b1);
        step();
        d32_accept = 32'h0;
        #1 check("n32_busy_done", d32_busy, 1'b0);
        check("n32_ifval_done", d32_if_val, 32'h0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Run-time guard
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
